// File: rtl/prog_const_pkg.sv
// Shared definitions for the programmable constant bank: FSM state encoding
// and the constant-function used to size the shift counter.
package prog_const_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   // Ceiling log2 for elaboration-time sizing; clog2(1) returns 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage : prog_const_pkg

// File: rtl/prog_const_bank_ccff_shift_reg.sv
// WIDTH-bit serial-in/parallel-out configuration register. New bits enter at
// bit 0 and leave through tail = q[WIDTH-1], one WIDTH-cycle hop per instance.
module ccff_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             serial,
   output logic [WIDTH-1:0] value,
   output logic             tail
);

   generate
      if (WIDTH == 1) begin : g_single
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               value <= '0;
            end else if (shift_en) begin
               value <= serial;
            end
         end
      end else begin : g_multi
         // NOTE: non-blocking assignment so every flop samples the pre-edge value of its neighbour.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               value <= '0;
            end else if (shift_en) begin
               value <= {value[WIDTH-2:0], serial};
            end
         end
      end
   endgenerate

   assign tail = value[WIDTH-1];

endmodule : ccff_shift_reg

// File: rtl/prog_const_bank.sv
// Field-programmable tie-off bank: a serially loaded pattern is committed to
// const_out only after a load of exactly WIDTH shifts.
module prog_const_bank
   import prog_const_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
   parameter int               CNT_W       = clog2(WIDTH + 2)
) (
   input  logic             prog_clk,
   input  logic             pReset,
   input  logic             config_en,
   input  logic             ccff_head,
   output logic             ccff_tail,
   output logic [WIDTH-1:0] const_out,
   output logic             config_done,
   output logic             config_err
);

   generate
      if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
         $error("prog_const_bank: WIDTH must be within 1..64");
      end
   endgenerate

   // cnt_sat is one past a full load and marks any over-length shift sequence.
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sr;

   ccff_shift_reg #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk      (prog_clk),
      .rst      (pReset),
      .shift_en (config_en),
      .serial   (ccff_head),
      .value    (sr),
      .tail     (ccff_tail)
   );

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         const_out   <= RESET_VALUE;
         config_done <= 1'b0;
         config_err  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (config_en) begin
                  state <= ST_LOAD;
                  cnt   <= CNT_ONE;
               end
            end

            ST_LOAD: begin
               if (config_en) begin
                  if (cnt != CNT_SAT) begin
                     cnt <= cnt + CNT_ONE;
                  end
               end else if (cnt == CNT_FULL) begin
                  const_out   <= sr;
                  config_done <= 1'b1;
                  state       <= ST_DONE;
               end else begin
                  config_err <= 1'b1;
                  state      <= ST_ERR;
               end
            end

            ST_DONE, ST_ERR: begin
               if (config_en) begin
                  config_done <= 1'b0;
                  config_err  <= 1'b0;
                  cnt         <= CNT_ONE;
                  state       <= ST_LOAD;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : prog_const_bank

// File: tb/tb_prog_const_bank.sv
// Bench for prog_const_bank (WIDTH=4): table-driven loads with a result
// scoreboard, plus mid-load reset and a two-instance chain.
module tb_prog_const_bank;

   localparam int         W  = 4;
   localparam logic [3:0] RV = 4'b0101;

   typedef struct {
      int         n;
      logic [7:0] seq;
      logic [3:0] exp_c;
      logic       exp_d;
      logic       exp_e;
      string      name;
   } vec_t;

   typedef struct {
      logic [3:0] c;
      logic       d;
      logic       e;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en_a = 1'b0;
   logic       en_b = 1'b0;
   logic       head = 1'b0;
   logic       tail_a, tail_b;
   logic [3:0] const_a, const_b;
   logic       done_a, done_b, err_a, err_b;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic hist[$];
   logic [3:0] committed;
   vec_t vecs[4];

   always #5 clk = ~clk;

   prog_const_bank #(.WIDTH(W), .RESET_VALUE(RV)) dut_a (
      .prog_clk    (clk),
      .pReset      (rst),
      .config_en   (en_a),
      .ccff_head   (head),
      .ccff_tail   (tail_a),
      .const_out   (const_a),
      .config_done (done_a),
      .config_err  (err_a)
   );

   prog_const_bank #(.WIDTH(W), .RESET_VALUE(RV)) dut_b (
      .prog_clk    (clk),
      .pReset      (rst),
      .config_en   (en_b),
      .ccff_head   (tail_a),
      .ccff_tail   (tail_b),
      .const_out   (const_b),
      .config_done (done_b),
      .config_err  (err_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_tail();
      return (hist.size() >= W) ? hist[hist.size() - W] : 1'b0;
   endfunction

   task automatic pop_and_check(input logic [3:0] c, input logic d, input logic e);
      exp_t x;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got no entry, expected one at %0t", $time);
      end else begin
         checks--;
         x = sb.pop_front();
         check({x.name, "_const"}, c, x.c);
         check({x.name, "_done"},  d, x.d);
         check({x.name, "_err"},   e, x.e);
         check({x.name, "_excl"},  d & e, 1'b0);
      end
   endtask

   // Shift n bits (first bit = seq[n-1]) into instance a, then one idle edge to commit.
   task automatic run_load(input vec_t v);
      sb.push_back('{c: v.exp_c, d: v.exp_d, e: v.exp_e, name: v.name});
      for (int i = 0; i < v.n; i++) begin
         head = v.seq[v.n-1-i];
         en_a = 1'b1;
         @(posedge clk); #1;
         hist.push_back(v.seq[v.n-1-i]);
         check({v.name, "_hold"},  const_a, committed);
         check({v.name, "_busy"},  {done_a, err_a}, 2'b00);
         check({v.name, "_tail"},  tail_a, exp_tail());
      end
      en_a = 1'b0;
      head = 1'b0;
      @(posedge clk); #1;
      pop_and_check(const_a, done_a, err_a);
      committed = v.exp_c;
      @(posedge clk); #1;
      check({v.name, "_keep"}, {const_a, done_a, err_a}, {v.exp_c, v.exp_d, v.exp_e});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      vecs[0] = '{4, 8'b0000_1011, 4'b1011, 1'b1, 1'b0, "good_1011"};
      vecs[1] = '{3, 8'b0000_0111, 4'b1011, 1'b0, 1'b1, "short_111"};
      vecs[2] = '{4, 8'b0000_0010, 4'b0010, 1'b1, 1'b0, "good_0010"};
      vecs[3] = '{6, 8'b0011_0100, 4'b0010, 1'b0, 1'b1, "over_6"};

      repeat (3) @(posedge clk);
      #1;
      check("reset_const", const_a, RV);
      check("reset_flags", {done_a, err_a}, 2'b00);
      check("reset_tail",  tail_a, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_const", const_a, RV);
      check("idle_const_b", const_b, RV);
      committed = RV;

      for (int k = 0; k < 4; k++) begin
         run_load(vecs[k]);
      end

      // Reset during a load: two shifts, then an asynchronous reset between edges.
      for (int i = 0; i < 2; i++) begin
         head = 1'b1;
         en_a = 1'b1;
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      check("midrst_const", const_a, RV);
      check("midrst_flags", {done_a, err_a}, 2'b00);
      check("midrst_tail",  tail_a, 1'b0);
      en_a = 1'b0;
      head = 1'b0;
      hist.delete();
      committed = RV;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      v = '{4, 8'b0000_1100, 4'b1100, 1'b1, 1'b0, "after_rst_1100"};
      run_load(v);

      // Chain 1,0,0,0,1,1,1,1: upstream loads 1,0,0,0 alone, then both shift 1,1,1,1.
      v = '{4, 8'b0000_1000, 4'b1000, 1'b1, 1'b0, "chain_up_first"};
      run_load(v);
      check("chain_b_pre", const_b, RV);
      sb.push_back('{c: 4'b1111, d: 1'b1, e: 1'b0, name: "chain_up"});
      sb.push_back('{c: 4'b1000, d: 1'b1, e: 1'b0, name: "chain_down"});
      for (int i = 0; i < 4; i++) begin
         head = 1'b1;
         en_a = 1'b1;
         en_b = 1'b1;
         @(posedge clk); #1;
         hist.push_back(1'b1);
         check("chain_hold_a", const_a, committed);
         check("chain_hold_b", const_b, RV);
         check("chain_tail_a", tail_a, exp_tail());
      end
      en_a = 1'b0;
      en_b = 1'b0;
      head = 1'b0;
      @(posedge clk); #1;
      pop_and_check(const_a, done_a, err_a);
      pop_and_check(const_b, done_b, err_b);
      check("chain_tail_b", tail_b, 1'b1);
      check("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_prog_const_bank
